rf_audio_stream_packer: RTL and testbench
=========================================

# rf_audio_stream_packer

Parametrised successor to the fixed RF/audio data generator. Sits between the RF ADC, the audio capture blocks (ADC128S022 controller, PCM1802 slave) and the FIFO buffer, all in the ADC clock domain. Each clock it packs one RF sample into the low bits of a DATA_WIDTH word. The spare high bits carry a framed side-channel holding up to four audio channels, a sync marker and status. Mode changes are applied only at frame boundaries, so no partial frames are ever emitted.

## Interface
- RF_WIDTH, 10: RF sample width.
- DATA_WIDTH, 16: output word width. SIDE_WIDTH = DATA_WIDTH-RF_WIDTH, must be ≥6.
- AUDIO_CHANNELS, 4: channel count, range 1..4.
- AUDIO_WIDTH, 24: audio sample width. SLICES = ceil(AUDIO_WIDTH/SIDE_WIDTH).
- FRAME_WORDS, 512: words per frame. Must satisfy 2+AUDIO_CHANNELS*SLICES ≤ FRAME_WORDS.

Ports:
- clock  in  1  ADC sample clock; the only clock.
- nReset  in  1  synchronous, active-low reset.
- adc_databus  in  RF_WIDTH  RF sample, valid every cycle.
- mode_req  in  2  requested mode: 00 RF, 01 RF+audio, 10 test16, 11 test+audio.
- audio_samples  in  AUDIO_CHANNELS*AUDIO_WIDTH  channel c at bits [c*AUDIO_WIDTH +: AUDIO_WIDTH].
- audio_ready  in  AUDIO_CHANNELS  one-cycle strobe per channel; sample valid in that cycle.
- dataOut  out  DATA_WIDTH  packed word, one per cycle.
- frame_start  out  1  high while dataOut holds word 0 of a frame.
- audio_overrun  out  1  sticky overrun flag, cleared only by reset.

## Operation
- word_idx counts 0..FRAME_WORDS-1 and wraps. seq is a 2-bit counter that increments at each wrap.
- At word_idx==0 (the snapshot cycle):
  - active mode ← mode_req.
  - Each channel's holding register is copied to the slice buffer.
  - fresh[c] ← pending[c]; pending[c] is cleared.
- audio_ready[c] loads holding[c] and sets pending[c].
  - If pending[c] is already set, the new sample replaces the old one and audio_overrun is set.
  - A strobe in the snapshot cycle goes to the next frame: snapshot takes the prior holding value, and pending is set afterwards. This does not count as an overrun.
- RF field (dataOut[RF_WIDTH-1:0]) by mode:
  - 00/01: adc_databus.
  - 11: test counter modulo 2^RF_WIDTH.
- Side field (dataOut[DATA_WIDTH-1:RF_WIDTH]) by mode:
  - 00: zero.
  - 10: no separate fields; the whole word is a 16-bit wrapping counter.
  - 01/11, word 0: all ones (SYNC).
  - 01/11, word 1: {seq, fresh[3:0]} in the top 6 bits; unused channel bits are 0 and any remaining low bits are 0.
  - 01/11, words 2+c*SLICES+k, k=0..SLICES-1: slice k of the channel-c snapshot, MSB first. The last slice is zero-padded at the LSB end.
  - 01/11, all remaining words: zero.
- The test counter resets to 0 and increments every cycle in modes 10/11.

## Timing
- Two-stage pipeline: adc_databus registered, then dataOut registered. Latency is 2 cycles from input to dataOut. frame_start is aligned with dataOut.
- Reset values: dataOut=0, frame_start=0, audio_overrun=0, word_idx=0, seq=0, active mode=00, pending/fresh/holding/slices=0, test counter=0.
- First cycle after reset release is the snapshot cycle. frame_start is then 1, two cycles later.
- A mode_req change mid-frame has no effect until the next word 0. A toggle that reverts before word 0 is never seen.
- Reset mid-frame aborts the frame. dataOut is 0 during reset; no partial frame is resumed.

## Structure
- Package stream_pkg holds:
  - mode encodings MODE_RF, MODE_RF_AUDIO, MODE_TEST16, MODE_TEST_AUDIO;
  - SYNC side value (all ones);
  - word-index constants WORD_SYNC=0, WORD_STATUS=1, WORD_AUDIO0=2;
  - ceil-divide function for SLICES.
- Sub-module audio_channel_capture holds one channel's holding register plus pending/fresh/overrun logic. It is instantiated AUDIO_CHANNELS times via generate.

## Test plan
- Reset, mode_req=00, adc ramp 0..1023 → dataOut equals the ramp delayed 2 cycles, side field 0, frame_start every 512 cycles.
- mode 01, channel 0 strobe 0xABCDEF once per frame → word0 side 0x3F; word1 side {seq,0001}; words 2..5 side 0x2A,0x3C,0x37,0x2F; frame_start on word 0 only.
- mode 01, two channel-1 strobes in one frame (0x111111, then 0x222222) → next frame carries 0x222222 and audio_overrun=1 until reset.
- Strobe on the snapshot cycle → value appears in the following frame; fresh bit is 0 in the current frame; no overrun.
- Switch mode_req 01→10 at word 100 → audio framing continues to word 511; the 16-bit counter starts at word 0 with value 0.
- Assert nReset at word 300 → dataOut=0 next cycle; after release, a new frame begins with seq=0.

Source files
------------

// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - mode encodings, frame layout constants and sizing helper for the RF/audio packer
package stream_pkg;

  typedef enum logic [1:0] {
    MODE_RF         = 2'b00,
    MODE_RF_AUDIO   = 2'b01,
    MODE_TEST16     = 2'b10,
    MODE_TEST_AUDIO = 2'b11
  } mode_e;

  // Wide enough for any side field; callers truncate to their own width.
  localparam logic [63:0] SYNC_SIDE = '1;

  localparam int WORD_SYNC   = 0;
  localparam int WORD_STATUS = 1;
  localparam int WORD_AUDIO0 = 2;

  localparam int TEST_CNT_WIDTH = 16;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/audio_channel_capture.sv
// rtl/audio_channel_capture.sv - one audio channel: holding register, pending/fresh tracking, sticky overrun
module audio_channel_capture #(
  parameter int AUDIO_WIDTH = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   snap_i,
  input  logic                   ready_i,
  input  logic [AUDIO_WIDTH-1:0] sample_i,
  output logic [AUDIO_WIDTH-1:0] snap_o,
  output logic                   fresh_o,
  output logic                   overrun_o
);

  logic [AUDIO_WIDTH-1:0] hold_q;
  logic [AUDIO_WIDTH-1:0] snap_q;
  logic                   pend_q;
  logic                   fresh_q;
  logic                   ovr_q;

  // Snapshot takes the value held before this cycle; a strobe landing on the
  // snapshot cycle is queued for the next frame and never counts as overrun.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_q  <= '0;
      snap_q  <= '0;
      pend_q  <= 1'b0;
      fresh_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (ready_i) begin
        hold_q <= sample_i;
      end
      if (snap_i) begin
        snap_q  <= hold_q;
        fresh_q <= pend_q;
        pend_q  <= ready_i;
      end else if (ready_i) begin
        pend_q <= 1'b1;
        if (pend_q) begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign snap_o    = snap_q;
  assign fresh_o   = fresh_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/rf_audio_stream_packer.sv
// rtl/rf_audio_stream_packer.sv - packs RF samples with a framed audio/status side-channel into output words
module rf_audio_stream_packer
  import stream_pkg::*;
#(
  parameter int RF_WIDTH       = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int AUDIO_CHANNELS = 4,
  parameter int AUDIO_WIDTH    = 24,
  parameter int FRAME_WORDS    = 512
) (
  input  logic                                  clock,
  input  logic                                  nReset,
  input  logic [RF_WIDTH-1:0]                   adc_databus,
  input  logic [1:0]                            mode_req,
  input  logic [AUDIO_CHANNELS*AUDIO_WIDTH-1:0] audio_samples,
  input  logic [AUDIO_CHANNELS-1:0]             audio_ready,
  output logic [DATA_WIDTH-1:0]                 dataOut,
  output logic                                  frame_start,
  output logic                                  audio_overrun
);

  localparam int SIDE_WIDTH = DATA_WIDTH - RF_WIDTH;
  localparam int SLICES     = ceil_div(AUDIO_WIDTH, SIDE_WIDTH);
  localparam int PAD_WIDTH  = SLICES * SIDE_WIDTH;
  localparam int IDX_WIDTH  = $clog2(FRAME_WORDS);

  logic [RF_WIDTH-1:0]       adc_q;
  logic [IDX_WIDTH-1:0]      word_idx_q;
  logic [IDX_WIDTH-1:0]      out_idx_q;
  logic                      vld_q;
  logic [1:0]                seq_q;
  mode_e                     mode_q;
  logic [TEST_CNT_WIDTH-1:0] tcnt_q;
  logic [DATA_WIDTH-1:0]     data_d;
  logic [SIDE_WIDTH-1:0]     side_d;
  logic [RF_WIDTH-1:0]       rf_d;
  logic [PAD_WIDTH-1:0]      pad_d;
  logic                      snap_cycle;
  logic                      last_word;
  logic                      test_mode;
  logic [AUDIO_WIDTH-1:0]    snap [AUDIO_CHANNELS];
  logic [AUDIO_CHANNELS-1:0] fresh;
  logic [AUDIO_CHANNELS-1:0] ovr;

  assign snap_cycle    = (word_idx_q == '0);
  assign last_word     = (word_idx_q == IDX_WIDTH'(FRAME_WORDS - 1));
  assign test_mode     = (mode_q == MODE_TEST16) || (mode_q == MODE_TEST_AUDIO);
  assign audio_overrun = |ovr;

  for (genvar c = 0; c < AUDIO_CHANNELS; c++) begin : g_chan
    audio_channel_capture #(
      .AUDIO_WIDTH(AUDIO_WIDTH)
    ) u_cap (
      .clk_i    (clock),
      .rst_ni   (nReset),
      .snap_i   (snap_cycle),
      .ready_i  (audio_ready[c]),
      .sample_i (audio_samples[c*AUDIO_WIDTH +: AUDIO_WIDTH]),
      .snap_o   (snap[c]),
      .fresh_o  (fresh[c]),
      .overrun_o(ovr[c])
    );
  end

  // Second stage word assembly; out_idx_q is the frame position of the sample in adc_q.
  always_comb begin
    side_d = '0;
    rf_d   = adc_q;
    pad_d  = '0;
    if (mode_q == MODE_TEST_AUDIO) begin
      rf_d = RF_WIDTH'(tcnt_q);
    end
    if ((mode_q == MODE_RF_AUDIO) || (mode_q == MODE_TEST_AUDIO)) begin
      if (out_idx_q == IDX_WIDTH'(WORD_SYNC)) begin
        side_d = SIDE_WIDTH'(SYNC_SIDE);
      end else if (out_idx_q == IDX_WIDTH'(WORD_STATUS)) begin
        side_d = SIDE_WIDTH'({seq_q, 4'(fresh)}) << (SIDE_WIDTH - 6);
      end else begin
        for (int c = 0; c < AUDIO_CHANNELS; c++) begin
          for (int k = 0; k < SLICES; k++) begin
            if (out_idx_q == IDX_WIDTH'(WORD_AUDIO0 + c*SLICES + k)) begin
              pad_d  = PAD_WIDTH'(snap[c]) << (PAD_WIDTH - AUDIO_WIDTH);
              side_d = pad_d[(SLICES-1-k)*SIDE_WIDTH +: SIDE_WIDTH];
            end
          end
        end
      end
    end
    data_d = (mode_q == MODE_TEST16) ? DATA_WIDTH'(tcnt_q) : {side_d, rf_d};
  end

  // Frame counter, mode latch at word 0, and the two pipeline registers.
  always_ff @(posedge clock) begin
    if (!nReset) begin
      adc_q       <= '0;
      word_idx_q  <= '0;
      out_idx_q   <= '0;
      vld_q       <= 1'b0;
      seq_q       <= '0;
      mode_q      <= MODE_RF;
      tcnt_q      <= '0;
      dataOut     <= '0;
      frame_start <= 1'b0;
    end else begin
      adc_q      <= adc_databus;
      out_idx_q  <= word_idx_q;
      vld_q      <= 1'b1;
      word_idx_q <= last_word ? '0 : word_idx_q + 1'b1;
      if (last_word) begin
        seq_q <= seq_q + 1'b1;
      end
      if (snap_cycle) begin
        mode_q <= mode_e'(mode_req);
      end
      dataOut     <= vld_q ? data_d : '0;
      frame_start <= vld_q && (out_idx_q == '0);
      if (vld_q && test_mode) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_audio_stream_packer.sv
// tb/tb_rf_audio_stream_packer.sv - self-checking bench for rf_audio_stream_packer
module tb_rf_audio_stream_packer;

  localparam int RW  = 10;
  localparam int DW  = 16;
  localparam int SW  = 6;
  localparam int NCH = 4;
  localparam int AW  = 24;
  localparam int FW  = 512;
  localparam int SL  = 4;

  logic              clock = 1'b0;
  logic              nReset = 1'b0;
  logic [RW-1:0]     adc_databus = '0;
  logic [1:0]        mode_req = '0;
  logic [NCH*AW-1:0] audio_samples = '0;
  logic [NCH-1:0]    audio_ready = '0;
  logic [DW-1:0]     dataOut;
  logic              frame_start;
  logic              audio_overrun;

  always #5 clock = ~clock;

  rf_audio_stream_packer #(
    .RF_WIDTH(RW), .DATA_WIDTH(DW), .AUDIO_CHANNELS(NCH), .AUDIO_WIDTH(AW), .FRAME_WORDS(FW)
  ) dut (
    .clock        (clock),
    .nReset       (nReset),
    .adc_databus  (adc_databus),
    .mode_req     (mode_req),
    .audio_samples(audio_samples),
    .audio_ready  (audio_ready),
    .dataOut      (dataOut),
    .frame_start  (frame_start),
    .audio_overrun(audio_overrun)
  );

  typedef struct {
    logic [DW-1:0] word;
    logic          fs;
    int            idx;
  } exp_t;

  typedef struct {
    logic [1:0]       mode;
    int               ch;
    logic [AW-1:0]    s1;
    int               w1;
    logic [AW-1:0]    s2;
    int               w2;
    logic [0:17][5:0] side;
    logic             ovr;
  } vec_t;

  exp_t          sb[$];
  vec_t          vec[6];
  int            checks = 0;
  int            failures = 0;
  int            adc_ctr = 0;
  logic [DW-1:0] cap [FW];

  int            m_idx;
  logic [1:0]    m_seq;
  logic [1:0]    m_mode;
  logic [AW-1:0] m_hold [NCH];
  logic [AW-1:0] m_snap [NCH];
  logic [NCH-1:0] m_pend;
  logic [NCH-1:0] m_fresh;
  logic [15:0]   m_tcnt;
  logic          m_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_seq = '0; m_mode = '0; m_pend = '0; m_fresh = '0; m_tcnt = '0; m_ovr = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_hold[c] = '0;
      m_snap[c] = '0;
    end
  endtask

  task automatic model_step();
    exp_t          e;
    logic [5:0]    side;
    logic [RW-1:0] rf;
    int            c;
    int            k;
    if (m_idx == 0) begin
      m_mode = mode_req;
      for (int i = 0; i < NCH; i++) m_snap[i] = m_hold[i];
      m_fresh = m_pend;
      m_pend = '0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (audio_ready[i]) begin
        if (m_pend[i]) m_ovr = 1'b1;
        m_pend[i] = 1'b1;
        m_hold[i] = audio_samples[i*AW +: AW];
      end
    end
    rf = adc_databus;
    side = '0;
    if (m_mode == 2'b11) rf = m_tcnt[RW-1:0];
    if (m_mode[0]) begin
      if (m_idx == 0) side = 6'h3F;
      else if (m_idx == 1) side = {m_seq, m_fresh};
      else if (m_idx < 2 + NCH*SL) begin
        c = (m_idx - 2) / SL;
        k = (m_idx - 2) % SL;
        side = 6'(m_snap[c] >> (SW*(SL-1-k)));
      end
    end
    e.word = (m_mode == 2'b10) ? m_tcnt : {side, rf};
    if (m_mode[1]) m_tcnt = m_tcnt + 16'd1;
    e.fs = (m_idx == 0);
    e.idx = m_idx;
    sb.push_back(e);
    m_idx++;
    if (m_idx == FW) begin
      m_idx = 0;
      m_seq = m_seq + 2'd1;
    end
  endtask

  task automatic tick();
    exp_t e;
    adc_databus = RW'(adc_ctr);
    adc_ctr++;
    if (nReset) model_step();
    @(posedge clock);
    #1;
    if (!nReset) begin
      sb.delete();
      model_reset();
      check("rst_dataOut", 32'(dataOut), 32'd0);
      check("rst_frame_start", 32'(frame_start), 32'd0);
      check("rst_overrun", 32'(audio_overrun), 32'd0);
    end else begin
      check("audio_overrun", 32'(audio_overrun), 32'(m_ovr));
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        check($sformatf("dataOut_w%0d", e.idx), 32'(dataOut), 32'(e.word));
        check($sformatf("frame_start_w%0d", e.idx), 32'(frame_start), 32'(e.fs));
        cap[e.idx] = dataOut;
      end
    end
  endtask

  task automatic run_to(input int w);
    for (int i = 0; i <= FW && m_idx != w; i++) tick();
  endtask

  task automatic arm(input int ch, input logic [AW-1:0] val);
    audio_samples[ch*AW +: AW] = val;
    audio_ready[ch] = 1'b1;
  endtask

  task automatic fire();
    tick();
    audio_ready = '0;
  endtask

  task automatic do_reset(input int n);
    nReset = 1'b0;
    audio_ready = '0;
    repeat (n) tick();
    nReset = 1'b1;
  endtask

  task automatic check_side(input string tag, input logic [0:17][5:0] exp);
    for (int w = 0; w < 18; w++)
      check($sformatf("%s_side_w%0d", tag, w), 32'(cap[w][DW-1:RW]), 32'(exp[w]));
  endtask

  initial begin
    vec[0] = '{mode:2'b00, ch:0, s1:24'hABCDEF, w1:10, s2:24'h0, w2:-1,
               side:{18{6'h00}}, ovr:1'b0};
    vec[1] = '{mode:2'b01, ch:0, s1:24'hABCDEF, w1:10, s2:24'h0, w2:-1,
               side:{6'h3F, 6'h11, 6'h2A, 6'h3C, 6'h37, 6'h2F, {12{6'h00}}}, ovr:1'b0};
    vec[2] = '{mode:2'b01, ch:1, s1:24'h111111, w1:10, s2:24'h222222, w2:20,
               side:{6'h3F, 6'h12, {4{6'h00}}, 6'h08, 6'h22, 6'h08, 6'h22, {8{6'h00}}}, ovr:1'b1};
    vec[3] = '{mode:2'b11, ch:3, s1:24'h800001, w1:300, s2:24'h0, w2:-1,
               side:{6'h3F, 6'h18, {12{6'h00}}, 6'h20, 6'h00, 6'h00, 6'h01}, ovr:1'b0};
    vec[4] = '{mode:2'b01, ch:2, s1:24'hFFFFFF, w1:511, s2:24'h0, w2:-1,
               side:{6'h3F, 6'h14, {8{6'h00}}, {4{6'h3F}}, {4{6'h00}}}, ovr:1'b0};
    vec[5] = '{mode:2'b01, ch:0, s1:24'h123456, w1:0, s2:24'h0, w2:-1,
               side:{6'h3F, 6'h11, 6'h04, 6'h23, 6'h11, 6'h16, {12{6'h00}}}, ovr:1'b0};

    model_reset();
    do_reset(3);

    for (int v = 0; v < 6; v++) begin
      do_reset(2);
      mode_req = vec[v].mode;
      run_to(vec[v].w1);
      arm(vec[v].ch, vec[v].s1);
      fire();
      if (vec[v].w2 >= 0) begin
        run_to(vec[v].w2);
        arm(vec[v].ch, vec[v].s2);
        fire();
      end
      run_to(0);
      run_to(20);
      check_side($sformatf("vec%0d", v), vec[v].side);
      check($sformatf("vec%0d_overrun", v), 32'(audio_overrun), 32'(vec[v].ovr));
    end

    do_reset(2);
    mode_req = 2'b01;
    run_to(400);
    arm(1, 24'h111111);
    fire();
    run_to(0);
    arm(0, 24'hABCDEF);
    arm(1, 24'h222222);
    fire();
    run_to(20);
    check_side("snapstrobe_cur", {6'h3F, 6'h12, {4{6'h00}}, 6'h04, 6'h11, 6'h04, 6'h11, {8{6'h00}}});
    run_to(0);
    run_to(20);
    check_side("snapstrobe_next", {6'h3F, 6'h23, 6'h2A, 6'h3C, 6'h37, 6'h2F, 6'h08, 6'h22, 6'h08, 6'h22, {8{6'h00}}});
    check("snapstrobe_overrun", 32'(audio_overrun), 32'd0);

    do_reset(2);
    mode_req = 2'b01;
    run_to(100);
    mode_req = 2'b10;
    run_to(0);
    check("switch_sync_kept", 32'(cap[0][DW-1:RW]), 32'h3F);
    check("switch_frame_start_count", 32'(cap[300][DW-1:RW]), 32'h00);
    run_to(50);
    mode_req = 2'b00;
    run_to(60);
    mode_req = 2'b10;
    run_to(0);
    check("test16_w0", 32'(cap[0]), 32'd0);
    check("test16_w1", 32'(cap[1]), 32'd1);
    check("test16_w100", 32'(cap[100]), 32'd100);
    check("test16_w510", 32'(cap[510]), 32'd510);
    run_to(2);
    check("test16_w511", 32'(cap[511]), 32'd511);
    check("toggle_ignored_w0", 32'(cap[0]), 32'd512);

    mode_req = 2'b01;
    run_to(300);
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
    run_to(4);
    check("after_reset_sync", 32'(cap[0][DW-1:RW]), 32'h3F);
    check("after_reset_status", 32'(cap[1][DW-1:RW]), 32'h00);
    check("after_reset_slice0", 32'(cap[2][DW-1:RW]), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
